spi_sample_buffer: RTL

Single-clock SPI slave receive front end for the speech recognizer. Synchronizes the raw `sck`/`sdi`/`ss` pins into the `clk` domain, deserializes MSB-first 8-bit audio samples while `ss` is high, and queues them in a circular FIFO. The audio processing stage downstream drains the FIFO at its own pace. The block reports frame boundaries and overflow.

---
 rtl/speechrec_pkg.sv | 12 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/spi_sample_buffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/speechrec_pkg.sv
// Shared types and constants for the speech recognizer front end.
package speechrec_pkg;

  localparam int unsigned SAMPLE_W      = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with show-ahead read, wrap-bit pointers,
// occupancy level and a sticky overflow flag.
module sync_fifo
  import speechrec_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance and sticky overflow on a dropped push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_sample_buffer.sv
// SPI slave receive front end: pin synchronizers, edge detect, frame FSM,
// MSB-first deserializer and frame counter feeding a sample FIFO.
module spi_sample_buffer
  import speechrec_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned LENW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   sdi,
  input  logic                   ss,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   frame_done,
  output logic [LENW-1:0]        frame_len,
  output logic                   partial,
  output logic [7:0]             led
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic sck_s1, sck_s2, sck_s3;
  logic sdi_s1, sdi_s2;
  logic ss_s1, ss_s2, ss_s3;
  logic [1:0] settle;
  logic armed;

  logic sck_rise, ss_rise, ss_fall;

  rx_state_t        state;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_cnt_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [LENW-1:0]  frame_cnt;
  logic [LENW-1:0]  frame_cnt_inc;
  logic             last_bit;
  logic             sample_done;
  logic [7:0]       led_next;

  // Pin synchronizers, edge-detect history and post-reset arming.
  // After reset the synchronizers read 0, so a frame already in flight would
  // look like a fresh ss rise; arming waits until ss is genuinely seen low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_s3 <= 1'b0;
      sdi_s1 <= 1'b0; sdi_s2 <= 1'b0;
      ss_s1  <= 1'b0; ss_s2  <= 1'b0; ss_s3  <= 1'b0;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      sck_s1 <= sck;    sck_s2 <= sck_s1; sck_s3 <= sck_s2;
      sdi_s1 <= sdi;    sdi_s2 <= sdi_s1;
      ss_s1  <= ss;     ss_s2  <= ss_s1;  ss_s3  <= ss_s2;
      if (settle != 2'd3) settle <= settle + 1'b1;
      if (settle == 2'd3 && !ss_s2) armed <= 1'b1;
    end
  end

  assign sck_rise = sck_s2 && !sck_s3;
  assign ss_rise  = ss_s2 && !ss_s3 && armed;
  assign ss_fall  = !ss_s2 && ss_s3;

  // Next-state values for the shifter, bit counter and frame counter.
  always_comb begin
    sr_next       = {sr[WIDTH-2:0], sdi_s2};
    last_bit      = (bit_cnt == LAST_BIT);
    sample_done   = (state == RX_RECV) && sck_rise && last_bit;
    bit_cnt_next  = bit_cnt;
    if (sck_rise) bit_cnt_next = last_bit ? '0 : bit_cnt + 1'b1;
    frame_cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;
  end

  if (WIDTH >= 8) begin : g_led_wide
    assign led_next = sr_next[7:0];
  end else begin : g_led_narrow
    assign led_next = {{(8 - WIDTH){1'b0}}, sr_next};
  end

  // Frame FSM with registered status outputs.
  // A completing bit and ss fall in the same cycle are folded together so the
  // final sample is counted and does not flag the frame as partial.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      partial    <= 1'b0;
      led        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (sample_done) led <= led_next;
      case (state)
        RX_IDLE: begin
          if (ss_rise) begin
            state     <= RX_RECV;
            bit_cnt   <= '0;
            sr        <= '0;
            frame_cnt <= '0;
            partial   <= 1'b0;
          end
        end
        RX_RECV: begin
          if (sck_rise) begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt_next;
          end
          if (sample_done) frame_cnt <= frame_cnt_inc;
          if (ss_fall) begin
            state      <= RX_IDLE;
            frame_done <= 1'b1;
            frame_len  <= sample_done ? frame_cnt_inc : frame_cnt;
            partial    <= (bit_cnt_next != '0);
            bit_cnt    <= '0;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sample_done),
    .push_data (sr_next),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overflow  (overflow)
  );

endmodule
